// File: rtl/sd_pkg.sv
// Shared SD host constants: CRC widths/polynomials and the CRC engine state type.
`timescale 1ns/1ps
package sd_pkg;

  localparam int CRC7_W  = 7;
  localparam int CRC16_W = 16;

  localparam logic [CRC7_W-1:0]  CRC7_POLY  = 7'h09;
  localparam logic [CRC16_W-1:0] CRC16_POLY = 16'h1021;

  typedef enum logic {
    ACC,
    SHIFT
  } sd_crc_state_e;

endpackage

// File: rtl/sd_crc_lane.sv
// One serial CRC LFSR lane: absorbs a data bit on update_i, shifts toward zero on shift_i.
`timescale 1ns/1ps
module sd_crc_lane import sd_pkg::*; #(
  parameter int                   CRC_WIDTH = CRC7_W,
  parameter logic [CRC_WIDTH-1:0] POLY      = CRC7_POLY
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic                 update_i,
  input  logic                 shift_i,
  input  logic                 bit_i,
  output logic [CRC_WIDTH-1:0] crc_o
);

  logic [CRC_WIDTH-1:0] crc_q;
  logic                 inv;

  assign inv   = bit_i ^ crc_q[CRC_WIDTH-1];
  assign crc_o = crc_q;

  // NOTE: sequential state uses non-blocking assignments so every lane and the
  // shared FSM all see the pre-edge values within one clock.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      crc_q <= '0;
    end else if (clear_i) begin
      crc_q <= '0;
    end else if (update_i) begin
      crc_q <= {crc_q[CRC_WIDTH-2:0], 1'b0} ^ (inv ? POLY : '0);
    end else if (shift_i) begin
      // Emission drains the register, leaving it zero for the next frame.
      crc_q <= {crc_q[CRC_WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/sd_crc_lanes.sv
// Multi-lane SD CRC engine with serial shift-out; SD_CRC_CHECK_EN enables the
// per-lane zero-remainder check on crc_ok_o.
`timescale 1ns/1ps
module sd_crc_lanes import sd_pkg::*; #(
  parameter int                   NUM_LANES = 1,
  parameter int                   CRC_WIDTH = CRC7_W,
  parameter logic [CRC_WIDTH-1:0] POLY      = CRC7_POLY
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           clear_i,
  input  logic                           en_i,
  input  logic [NUM_LANES-1:0]           bit_i,
  input  logic                           shift_out_i,
  output logic [NUM_LANES*CRC_WIDTH-1:0] crc_o,
  output logic [NUM_LANES-1:0]           crc_bit_o,
  output logic                           crc_bit_valid_o,
  output logic                           shift_done_o,
  output logic [NUM_LANES-1:0]           crc_ok_o
);

  localparam int              CNT_W    = (CRC_WIDTH > 1) ? $clog2(CRC_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CRC_WIDTH - 1);

  sd_crc_state_e    state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             update;
  logic             shifting;

  // shift_out_i wins over en_i: the bit in the accept cycle is dropped.
  assign update   = (state_q == ACC) && en_i && !shift_out_i;
  assign shifting = (state_q == SHIFT);

  // NOTE: only control state is reset; there are no memories here, so every
  // flop gets a defined reset value through the async branch.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ACC;
      cnt_q   <= '0;
    end else if (clear_i) begin
      state_q <= ACC;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ACC: begin
          if (shift_out_i) begin
            state_q <= SHIFT;
            cnt_q   <= CNT_LOAD;
          end
        end
        SHIFT: begin
          if (cnt_q == '0) begin
            state_q <= ACC;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= ACC;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign crc_bit_valid_o = shifting;
  assign shift_done_o    = shifting && (cnt_q == '0);

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    logic [CRC_WIDTH-1:0] lane_crc;

    sd_crc_lane #(
      .CRC_WIDTH (CRC_WIDTH),
      .POLY      (POLY)
    ) u_lane (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clear_i  (clear_i),
      .update_i (update),
      .shift_i  (shifting),
      .bit_i    (bit_i[k]),
      .crc_o    (lane_crc)
    );

    assign crc_o[k*CRC_WIDTH +: CRC_WIDTH] = lane_crc;
    // Gated so the serial line idles low outside emission.
    assign crc_bit_o[k] = shifting & lane_crc[CRC_WIDTH-1];

`ifdef SD_CRC_CHECK_EN
    assign crc_ok_o[k] = (lane_crc == '0);
`else
    assign crc_ok_o[k] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_sd_crc_lanes.sv
// Directed bench: CMD-line CRC7 instance and 4-lane DAT CRC16 instance.
`timescale 1ns/1ps
module tb_sd_crc_lanes;

`ifdef SD_CRC_CHECK_EN
  localparam logic OK_EXP = 1'b1;
`else
  localparam logic OK_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 1 lane CRC7
  logic       clear_a = 1'b0, en_a = 1'b0, so_a = 1'b0;
  logic [0:0] bit_a = '0;
  logic [6:0] crc_a;
  logic [0:0] cb_a, ok_a;
  logic       cv_a, done_a;

  // 4 lanes CRC16
  logic        clear_b = 1'b0, en_b = 1'b0, so_b = 1'b0;
  logic [3:0]  bit_b = '0;
  logic [63:0] crc_b;
  logic [3:0]  cb_b, ok_b;
  logic        cv_b, done_b;

  int checks = 0;
  int errors = 0;

  sd_crc_lanes #(.NUM_LANES(1), .CRC_WIDTH(7), .POLY(7'h09)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear_a), .en_i(en_a), .bit_i(bit_a),
    .shift_out_i(so_a), .crc_o(crc_a), .crc_bit_o(cb_a), .crc_bit_valid_o(cv_a),
    .shift_done_o(done_a), .crc_ok_o(ok_a)
  );

  sd_crc_lanes #(.NUM_LANES(4), .CRC_WIDTH(16), .POLY(16'h1021)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clear_b), .en_i(en_b), .bit_i(bit_b),
    .shift_out_i(so_b), .crc_o(crc_b), .crc_bit_o(cb_b), .crc_bit_valid_o(cv_b),
    .shift_done_o(done_b), .crc_ok_o(ok_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Feed the low n bits of v MSB first; optional random idle gaps with en low.
  task automatic feed_a(input logic [7:0] v, input int n, input bit gaps);
    for (int i = n - 1; i >= 0; i--) begin
      if (gaps) begin
        int idle = $urandom_range(0, 2);
        for (int j = 0; j < idle; j++) begin
          en_a  = 1'b0;
          bit_a = 1'($urandom_range(0, 1));
          tick();
        end
      end
      en_a  = 1'b1;
      bit_a = v[i];
      tick();
    end
    en_a = 1'b0;
  endtask

  task automatic feed_cmd0(input bit gaps);
    feed_a(8'h40, 8, gaps);
    for (int i = 0; i < 4; i++) feed_a(8'h00, 8, gaps);
  endtask

  task automatic feed_cmd8();
    feed_a(8'h48, 8, 1'b0);
    feed_a(8'h00, 8, 1'b0);
    feed_a(8'h00, 8, 1'b0);
    feed_a(8'h01, 8, 1'b0);
    feed_a(8'hAA, 8, 1'b0);
  endtask

  task automatic clear_pulse_a();
    clear_a = 1'b1;
    tick();
    clear_a = 1'b0;
  endtask

  // Request emission and check all seven serial bits plus the done pulse.
  task automatic shift_a(input logic [6:0] exp, input string tag);
    so_a = 1'b1;
    tick();
    so_a = 1'b0;
    for (int i = 6; i >= 0; i--) begin
      check({tag, "_bit"}, 64'(cb_a), 64'(exp[i]));
      check({tag, "_valid"}, 64'(cv_a), 64'd1);
      check({tag, "_done"}, 64'(done_a), 64'(i == 0));
      tick();
    end
    check({tag, "_valid_end"}, 64'(cv_a), 64'd0);
    check({tag, "_crc_end"}, 64'(crc_a), 64'd0);
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_crc_a", 64'(crc_a), 64'd0);
    check("rst_cb_a", 64'(cb_a), 64'd0);
    check("rst_cv_a", 64'(cv_a), 64'd0);
    check("rst_done_a", 64'(done_a), 64'd0);
    check("rst_ok_a", 64'(ok_a), 64'(OK_EXP));
    check("rst_crc_b", crc_b, 64'd0);
    check("rst_ok_b", 64'(ok_b), 64'({4{OK_EXP}}));
    tick();
    rst_n = 1'b1;
    tick();

    // CMD0 and its serial emission
    feed_cmd0(1'b0);
    check("cmd0_crc", 64'(crc_a), 64'h4A);
    shift_a(7'h4A, "cmd0_shift");

    // Back-to-back: shift accepted right after done, drains zeros
    shift_a(7'h00, "b2b_shift");

    // CMD8, then the received CRC through the check path
    clear_pulse_a();
    feed_cmd8();
    check("cmd8_crc", 64'(crc_a), 64'h43);
    feed_a(8'h43, 7, 1'b0);
    check("cmd8_rem_good", 64'(crc_a), 64'd0);
    check("cmd8_ok_good", 64'(ok_a), 64'(OK_EXP));
    clear_pulse_a();
    feed_cmd8();
    feed_a(8'h42, 7, 1'b0);
    check("cmd8_rem_bad", 64'(crc_a), 64'h09);
    check("cmd8_ok_bad", 64'(ok_a), 64'd0);

    // CMD0 with idle gaps
    clear_pulse_a();
    feed_cmd0(1'b1);
    check("gap_crc", 64'(crc_a), 64'h4A);

    // shift_out and en together: bit dropped, en ignored while shifting
    so_a = 1'b1; en_a = 1'b1; bit_a = 1'b1;
    tick();
    so_a = 1'b0;
    check("accept_crc", 64'(crc_a), 64'h4A);
    check("accept_bit", 64'(cb_a), 64'd1);
    tick();
    check("shift2_crc", 64'(crc_a), 64'h14);
    check("shift2_bit", 64'(cb_a), 64'd0);
    tick();
    check("shift3_done", 64'(done_a), 64'd0);
    clear_a = 1'b1;
    tick();
    clear_a = 1'b0; en_a = 1'b0; bit_a = 1'b0;
    check("clr_crc", 64'(crc_a), 64'd0);
    check("clr_valid", 64'(cv_a), 64'd0);
    for (int i = 0; i < 8; i++) begin
      check("clr_no_done", 64'(done_a), 64'd0);
      tick();
    end

    // Asynchronous reset mid-shift
    feed_cmd0(1'b0);
    so_a = 1'b1;
    tick();
    so_a = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("arst_crc", 64'(crc_a), 64'd0);
    check("arst_valid", 64'(cv_a), 64'd0);
    check("arst_bit", 64'(cb_a), 64'd0);
    check("arst_done", 64'(done_a), 64'd0);
    check("arst_ok", 64'(ok_a), 64'(OK_EXP));
    #3 rst_n = 1'b1;
    tick();
    feed_cmd8();
    check("post_rst_crc", 64'(crc_a), 64'h43);

    // 4 lanes CRC16 over 512 bytes of 0xFF
    bit_b = 4'hF;
    en_b  = 1'b1;
    for (int i = 0; i < 512 * 8; i++) tick();
    en_b = 1'b0;
    for (int k = 0; k < 4; k++) check("dat_crc", 64'(crc_b[k*16 +: 16]), 64'h7FA1);
    check("dat_ok", 64'(ok_b), 64'd0);
    begin
      logic [15:0] exp16;
      exp16 = 16'h7FA1;
      so_b = 1'b1;
      tick();
      so_b = 1'b0;
      for (int i = 15; i >= 0; i--) begin
        check("dat_bits", 64'(cb_b), 64'({4{exp16[i]}}));
        check("dat_valid", 64'(cv_b), 64'd1);
        check("dat_done", 64'(done_b), 64'(i == 0));
        tick();
      end
    end
    check("dat_valid_end", 64'(cv_b), 64'd0);
    check("dat_crc_end", crc_b, 64'd0);
    check("dat_ok_end", 64'(ok_b), 64'({4{OK_EXP}}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
